sub_share_ctrl: RTL
===================

# sub_share_ctrl

Shared-subtractor controller for the FPU datapath. Four requesters (exponent-difference, normalisation-shift, rounding-adjust and spare units) compete for one W-bit `substractor`, which the block instantiates internally. Each accepted request runs through a three-state sequencer, and the result returns with a one-cycle per-requester acknowledge. Arbitration is round-robin or fixed priority, selected at compile time.

## Interface
Parameters:
- W, 32, operand and result width in bits.

Ports:
- clk  in  1  system clock; everything is rising-edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- Req_i  in  4  level request, one bit per requester; bit k belongs to requester k.
- Data_A_i  in  4*W  packed minuends; requester k drives bits [k*W+W-1 : k*W].
- Data_B_i  in  4*W  packed subtrahends, packed the same way.
- Ack_o  in/out: out  4  one-hot, one-cycle pulse; marks Data_S_o valid for the granted requester.
- Data_S_o  out  W  Data_A − Data_B modulo 2^W; holds until the next Ack_o.
- Borrow_o  out  1  1 when the unsigned A < B; valid with Ack_o and held like Data_S_o.
- Busy_o  out  1  high while the state is CALC or DONE.

## Operation
- State machine with three states: IDLE, CALC, DONE.
- IDLE:
  - If Req_i is nonzero, the arbiter picks a winner g.
  - The block latches A_g, B_g and g into internal registers and moves to CALC.
  - If Req_i is zero, the block stays in IDLE.
- CALC:
  - The internal substractor computes from the latched operands.
  - Result and borrow are registered from a W+1-bit subtraction: Borrow = bit W of ({1'b0,A} − {1'b0,B}).
  - Next state is DONE.
- DONE:
  - Ack_o[g] = 1; all other Ack_o bits are 0.
  - The last-grant pointer updates to g.
  - Next state is IDLE.
- Round-robin arbitration: search starts at (last+1) mod 4 and increments mod 4. The first requester found with Req_i set wins.
- Requester obligations:
  - Hold Req_i and its operands stable from assertion until it samples Ack_o high.
  - Req_i still high in the IDLE cycle after DONE is a new request. It is arbitrated normally, and the operands present at that point are used (back-to-back operation).
- Req_i[g] dropping during CALC or DONE does not abort the operation. The operation completes and Ack_o[g] still pulses.
- Operand changes after the latch cycle have no effect on the operation in flight.
- Req_i bits rising while Busy_o is high are considered only at the next IDLE.
- Reset:
  - rst_n low on any edge forces IDLE, even mid-operation. The in-flight result is discarded and no Ack_o is issued.
  - Reset values: Ack_o = 0, Data_S_o = 0, Borrow_o = 0, Busy_o = 0, last-grant pointer = 3, so requester 0 has first priority.

## Timing
- Request sampled in IDLE at cycle t → CALC at t+1 → DONE at t+2.
- Ack_o, Data_S_o and Borrow_o are valid during cycle t+2. Latency is 2 cycles from the sampling edge.
- Maximum throughput: one operation every 3 cycles.
- Data_S_o and Borrow_o are registered and update only on the edge entering DONE.
- All outputs are registered, so no combinational path runs from Req_i to Ack_o.
- The subtractor sits between two register stages. Its critical path is one W-bit subtraction.

## Configuration
- SUBCTRL_ROUND_ROBIN_EN defined: round-robin arbitration as described, with the last-grant pointer maintained.
- Not defined: fixed priority, requester 0 highest and requester 3 lowest. The last-grant pointer is not implemented, and every other behaviour is identical.

## Test plan
- Single request, W=32: reset, then Req_i=0001 with A0=0x0000_0010 and B0=0x0000_0003 → Ack_o=0001 exactly 2 cycles after sampling, Data_S_o=0x0000_000D, Borrow_o=0, Busy_o high for 2 cycles.
- Borrow and wrap: A1=0x0000_0001, B1=0x0000_0002 → Data_S_o=0xFFFF_FFFF, Borrow_o=1, Ack_o=0010.
- Contention with Req_i=1111 held, round-robin build:
  - Ack order is 0,1,2,3,0, three cycles apart.
  - With the macro off, requester 0 is acked every time.
- Request dropped mid-operation: deassert Req_i[2] during CALC → Ack_o[2] still pulses with the correct difference, and the next IDLE ignores requester 2.
- Reset mid-operation: rst_n low during CALC → next cycle state is IDLE, all outputs 0, no Ack_o pulse. A request after reset release gets requester 0 served first.
- Operand stability: change A3 during CALC → result reflects the operand latched in IDLE.

Source files
------------

// File: rtl/sub_share_ctrl.sv
// sub_share_ctrl: four-requester controller around one shared W-bit subtractor.
// Define SUBCTRL_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (0 highest).
module substractor #(parameter int W = 32) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] d,
   output logic         borrow
);
   assign {borrow, d} = {1'b0, a} - {1'b0, b};
endmodule

module sub_share_ctrl #(parameter int W = 32) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [3:0]     Req_i,
   input  logic [4*W-1:0] Data_A_i,
   input  logic [4*W-1:0] Data_B_i,
   output logic [3:0]     Ack_o,
   output logic [W-1:0]   Data_S_o,
   output logic           Borrow_o,
   output logic           Busy_o
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nx;
   logic [W-1:0] a_q, b_q, d;
   logic [1:0] g_q, gnt;
   logic borrow;
`ifdef SUBCTRL_ROUND_ROBIN_EN
   logic [1:0] last_q;
   // descending scan so the nearest requester after last_q is assigned last and wins
   always_comb begin
      gnt = last_q;
      for (int i = 4; i >= 1; i--)
         if (Req_i[last_q + 2'(i)]) gnt = last_q + 2'(i);
   end
   always_ff @(posedge clk)
      if (!rst_n) last_q <= 2'd3;
      else if (state == DONE) last_q <= g_q;
`else
   assign gnt = Req_i[0] ? 2'd0 : Req_i[1] ? 2'd1 : Req_i[2] ? 2'd2 : 2'd3;
`endif
   substractor #(.W(W)) u_sub (.a(a_q), .b(b_q), .d(d), .borrow(borrow));
   always_ff @(posedge clk)
      state <= !rst_n ? IDLE : state_nx;
   always_comb begin
      state_nx = state;
      state_nx = (state == IDLE) ? (|Req_i ? CALC : IDLE) : (state == CALC) ? DONE : IDLE;
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         Ack_o    <= 4'b0000;
         Data_S_o <= '0;
         Borrow_o <= 1'b0;
         Busy_o   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         g_q      <= 2'd0;
      end else begin
         Busy_o <= state_nx != IDLE;
         Ack_o  <= (state == CALC) ? 4'b0001 << g_q : 4'b0000;
         if (state == IDLE && |Req_i) begin
            a_q <= Data_A_i[gnt*W +: W];
            b_q <= Data_B_i[gnt*W +: W];
            g_q <= gnt;
         end
         if (state == CALC) begin
            Data_S_o <= d;
            Borrow_o <= borrow;
         end
      end
endmodule
